fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, PC value loaded at reset.
REQ-002 Parameter TIMEOUT_CYCLES, default 16, REQ+WAIT cycle limit; used only with FETCH_TIMEOUT_EN.
REQ-003 clk  input  1  single clock; all state on posedge clk.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 phase_fetch  input  1  state machine is in FETCH.
REQ-006 phase_writeback  input  1  state machine is in WRITEBACK.
REQ-007 stall_writeback  input  1  WRITEBACK held this cycle.
REQ-008 jump_en  input  1  branch/jump taken, valid during WRITEBACK.
REQ-009 jump_addr  input  32  branch/jump target.
REQ-010 imem_req  output  1  instruction memory request, registered.
REQ-011 imem_addr  output  32  request address, equal to pc.
REQ-012 imem_gnt  input  1  memory accepts request.
REQ-013 imem_rvalid  input  1  read data valid.
REQ-014 imem_rdata  input  32  read data.
REQ-015 stall_fetch  output  1  holds the state machine in FETCH.
REQ-016 pc  output  32  address of the current instruction.
REQ-017 inst  output  32  latched instruction.
REQ-018 fetch_err  output  1  sticky fetch timeout flag.

Function
REQ-019 Internal FSM SHALL have three states:
- IDLE: imem_req=0.
- REQ: imem_req=1.
- WAIT: imem_req=0.
REQ-020 FSM transitions SHALL be:
- IDLE->REQ when phase_fetch=1.
- REQ->WAIT when imem_gnt=1.
- WAIT->IDLE when imem_rvalid=1.
- Otherwise the state holds.
REQ-021 imem_rvalid in IDLE or REQ SHALL be ignored, and imem_gnt outside REQ SHALL be ignored.
REQ-022 stall_fetch SHALL be combinational: phase_fetch & ~(state==WAIT & imem_rvalid).
- The state machine therefore leaves FETCH on the same edge the data arrives.
REQ-023 On the edge where WAIT & imem_rvalid, inst SHALL load imem_rdata; inst SHALL otherwise hold.
REQ-024 Minimum FETCH residency SHALL be 3 cycles (IDLE, REQ with gnt, WAIT with rvalid); each gnt or rvalid wait cycle adds one.
REQ-025 If phase_fetch deasserts in REQ or WAIT, the transaction SHALL still complete and inst SHALL still load.
REQ-026 pc SHALL update only on an edge where phase_writeback=1 and stall_writeback=0:
- jump_en=1: pc <= {jump_addr[31:2],2'b00}.
- jump_en=0: pc <= pc+4, modulo 2^32, so 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-027 jump_en SHALL be ignored outside that update edge.
REQ-028 imem_addr SHALL equal pc at all times; pc bits [1:0] SHALL always be 0.

Reset
REQ-029 Asserting rst_n=0 SHALL immediately, regardless of clk:
- set state=IDLE, imem_req=0, pc=RESET_VECTOR with bits[1:0] cleared;
- set inst=32'h0000_0013 (NOP) and fetch_err=0.
REQ-030 Reset in REQ or WAIT SHALL abandon the transaction; a later imem_rvalid SHALL be ignored because the FSM is in IDLE.
REQ-031 The first request after reset release SHALL occur only after phase_fetch is sampled high.

Configuration
REQ-032 With macro FETCH_TIMEOUT_EN defined:
- A counter SHALL clear on IDLE->REQ and increment each cycle in REQ or WAIT.
- When the counter reaches TIMEOUT_CYCLES without completion, on that edge: FSM->IDLE, inst<=32'h0000_0013, fetch_err<=1 (sticky until reset).
- stall_fetch SHALL also be 0 in that timeout cycle.
REQ-033 Without FETCH_TIMEOUT_EN: no counter; fetch_err tied to 0; the FSM waits indefinitely for imem_gnt and imem_rvalid.

Verification
REQ-034 Reset, then phase_fetch=1, gnt and rvalid each on first opportunity with rdata=32'h00A0_0093:
- imem_req high exactly 1 cycle with imem_addr=0;
- stall_fetch 1,1,0; inst=32'h00A0_0093.
REQ-035 gnt delayed 2 cycles and rvalid delayed 3 cycles: stall_fetch high for 7 cycles; imem_req held for 3 cycles.
REQ-036 WRITEBACK with stall_writeback 1 then 0, and jump_en=0, pc=32'hFFFF_FFFC: pc changes once only, to 32'h0000_0000.
REQ-037 WRITEBACK with jump_en=1 and jump_addr=32'h0000_1237: pc=32'h0000_1234; next imem_addr=32'h0000_1234.
REQ-038 rst_n pulsed low in WAIT, then rvalid with rdata=32'hDEAD_BEEF: inst stays 32'h0000_0013; imem_req=0; pc=RESET_VECTOR.
REQ-039 With FETCH_TIMEOUT_EN, TIMEOUT_CYCLES=16 and no gnt:
- fetch_err rises after 16 REQ cycles;
- inst=32'h0000_0013;
- stall_fetch drops that cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction fetch stage of a multi-cycle core. Issues a single
//   request/grant/rvalid transaction to instruction memory while the core
//   sits in its FETCH phase, latches the returned instruction, and advances
//   or redirects the program counter during WRITEBACK.
//
// Configuration macro:
//   FETCH_TIMEOUT_EN - when defined, a transaction that has not completed
//                      after TIMEOUT_CYCLES cycles in REQ/WAIT is abandoned:
//                      inst becomes a NOP and the sticky fetch_err is raised.
//                      When undefined, fetch_err is constant 0 and the stage
//                      waits indefinitely.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   phase_fetch       core is in FETCH
//   phase_writeback   core is in WRITEBACK
//   stall_writeback   WRITEBACK held this cycle (pc must not move)
//   jump_en/jump_addr branch/jump redirect, sampled on the pc update edge
//   imem_req/addr     registered request, address always equals pc
//   imem_gnt          memory accepted the request
//   imem_rvalid/rdata read data return
//   stall_fetch       combinational hold of the core in FETCH
//   pc                current instruction address (word aligned)
//   inst              latched instruction
//   fetch_err         sticky fetch timeout flag
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR   = 32'h0000_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        phase_fetch,
    input  logic        phase_writeback,
    input  logic        stall_writeback,
    input  logic        jump_en,
    input  logic [31:0] jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        stall_fetch,
    output logic [31:0] pc,
    output logic [31:0] inst,
    output logic        fetch_err
);

    localparam logic [31:0] NOP_INST = 32'h0000_0013;
    localparam logic [31:0] PC_RESET = {RESET_VECTOR[31:2], 2'b00};

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } state_t;

    state_t      state_r;
    logic        imem_req_r;
    logic [31:0] pc_r;
    logic [31:0] inst_r;
    logic        fetch_err_r;
    logic        done_s;
    logic        timeout_s;
    logic        unused_s;

    // Data can only complete a transaction once the grant has moved us to WAIT.
    assign done_s = (state_r == ST_WAIT) && imem_rvalid;

`ifdef FETCH_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt_r;

    // The counter holds the number of REQ/WAIT cycles already elapsed, so the
    // limit is hit in the TIMEOUT_CYCLES-th busy cycle. Completion wins a tie.
    assign timeout_s = (state_r != ST_IDLE) && (tmo_cnt_r == CNT_LAST) && !done_s;

    // Busy-cycle counter, cleared when a new request is launched.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if ((state_r == ST_IDLE) && phase_fetch) begin
            tmo_cnt_r <= {CNT_W{1'b0}};
        end else if (state_r != ST_IDLE) begin
            tmo_cnt_r <= tmo_cnt_r + CNT_W'(1);
        end else begin
            tmo_cnt_r <= tmo_cnt_r;
        end
    end

    assign unused_s = ^jump_addr[1:0];
`else
    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT_CYCLES);

    assign timeout_s = 1'b0;
    assign unused_s  = ^{jump_addr[1:0], TIMEOUT_W[0]};
`endif

    // Release the core on the very edge the data (or a timeout) arrives.
    assign stall_fetch = phase_fetch && !done_s && !timeout_s;

    // Request FSM; imem_req is registered alongside the state it mirrors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            imem_req_r <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (phase_fetch) begin
                        state_r    <= ST_REQ;
                        imem_req_r <= 1'b1;
                    end else begin
                        state_r    <= ST_IDLE;
                        imem_req_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (timeout_s) begin
                        state_r    <= ST_IDLE;
                        imem_req_r <= 1'b0;
                    end else if (imem_gnt) begin
                        state_r    <= ST_WAIT;
                        imem_req_r <= 1'b0;
                    end else begin
                        state_r    <= ST_REQ;
                        imem_req_r <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (done_s || timeout_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                    imem_req_r <= 1'b0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    imem_req_r <= 1'b0;
                end
            endcase
        end
    end

    // Instruction latch: returned data, or a NOP when the fetch is abandoned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inst_r <= NOP_INST;
        end else if (done_s) begin
            inst_r <= imem_rdata;
        end else if (timeout_s) begin
            inst_r <= NOP_INST;
        end else begin
            inst_r <= inst_r;
        end
    end

    // Sticky error flag; only a reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_err_r <= 1'b0;
        end else if (timeout_s) begin
            fetch_err_r <= 1'b1;
        end else begin
            fetch_err_r <= fetch_err_r;
        end
    end

    // Program counter: moves only on an unstalled WRITEBACK edge, word aligned.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r <= PC_RESET;
        end else if (phase_writeback && !stall_writeback) begin
            if (jump_en) begin
                pc_r <= {jump_addr[31:2], 2'b00};
            end else begin
                pc_r <= pc_r + 32'd4;
            end
        end else begin
            pc_r <= pc_r;
        end
    end

    assign imem_req  = imem_req_r;
    assign imem_addr = pc_r;
    assign pc        = pc_r;
    assign inst      = inst_r;
    assign fetch_err = fetch_err_r;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Self-checking bench for fetch_stage. A memory responder with random
//   grant/data latencies drives each fetch; expectations are derived at the
//   transaction level (latencies -> cycle counts, returned word -> inst) and
//   a plain arithmetic pc model tracks writeback updates.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        phase_fetch;
    logic        phase_writeback;
    logic        stall_writeback;
    logic        jump_en;
    logic [31:0] jump_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        stall_fetch;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        fetch_err;

    int checks   = 0;
    int failures = 0;

    logic [31:0] pc_m;
    logic [31:0] inst_m;

    fetch_stage #(
        .RESET_VECTOR  (32'h0000_0000),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .phase_fetch    (phase_fetch),
        .phase_writeback(phase_writeback),
        .stall_writeback(stall_writeback),
        .jump_en        (jump_en),
        .jump_addr      (jump_addr),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .stall_fetch    (stall_fetch),
        .pc             (pc),
        .inst           (inst),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One fetch transaction: grant after g REQ cycles, data after r WAIT cycles.
    // With drop set, phase_fetch is released right after the IDLE cycle.
    task automatic do_fetch(input int g, input int r, input logic [31:0] data, input bit drop);
        int  gl      = g;
        int  rl      = r;
        int  req_c   = 0;
        int  stall_c = 0;
        bit  granted = 1'b0;
        bit  done    = 1'b0;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge clk);
            phase_writeback = 1'b0;
            jump_en         = 1'($urandom);
            jump_addr       = $urandom;
            if (cyc == 0) begin
                check_eq("req_before_fetch", {31'd0, imem_req}, 32'd0);
                phase_fetch = 1'b1;
                imem_gnt    = 1'($urandom);
                imem_rvalid = 1'($urandom);
                imem_rdata  = $urandom;
            end else begin
                if (drop) phase_fetch = 1'b0;
                if (imem_req) begin
                    req_c++;
                    check_eq("req_addr", imem_addr, pc_m);
                    if (gl == 0) begin
                        imem_gnt = 1'b1;
                        granted  = 1'b1;
                    end else begin
                        imem_gnt = 1'b0;
                        gl--;
                    end
                    imem_rvalid = 1'($urandom);
                    imem_rdata  = $urandom;
                end else if (granted) begin
                    imem_gnt = 1'($urandom);
                    if (rl == 0) begin
                        imem_rvalid = 1'b1;
                        imem_rdata  = data;
                        done        = 1'b1;
                    end else begin
                        rl--;
                        imem_rvalid = 1'b0;
                        imem_rdata  = $urandom;
                    end
                end else begin
                    imem_gnt    = 1'($urandom);
                    imem_rvalid = 1'($urandom);
                    imem_rdata  = $urandom;
                end
            end
            #1;
            if (stall_fetch) stall_c++;
            if (done) break;
        end
        check_eq("fetch_completed", {31'd0, done}, 32'd1);
        if (done) inst_m = data;
        @(negedge clk);
        phase_fetch = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        check_eq("req_cycles", 32'(req_c), 32'(g + 1));
        check_eq("stall_cycles", 32'(stall_c), drop ? 32'd1 : 32'(g + r + 2));
        check_eq("inst_loaded", inst, inst_m);
        check_eq("req_after_fetch", {31'd0, imem_req}, 32'd0);
    endtask

    // WRITEBACK of s stalled cycles (random jump inputs) then one update edge.
    task automatic do_wb(input int s, input bit jmp, input logic [31:0] addr);
        for (int i = 0; i < s; i++) begin
            @(negedge clk);
            check_eq("pc_hold", pc, pc_m);
            phase_writeback = 1'b1;
            stall_writeback = 1'b1;
            jump_en         = 1'($urandom);
            jump_addr       = $urandom;
        end
        @(negedge clk);
        check_eq("pc_hold", pc, pc_m);
        phase_writeback = 1'b1;
        stall_writeback = 1'b0;
        jump_en         = jmp;
        jump_addr       = addr;
        pc_m            = jmp ? (addr & 32'hFFFF_FFFC) : (pc_m + 32'd4);
        @(negedge clk);
        phase_writeback = 1'b0;
        stall_writeback = 1'($urandom);
        jump_en         = 1'($urandom);
        check_eq("pc_update", pc, pc_m);
        check_eq("imem_addr_eq_pc", imem_addr, pc_m);
        check_eq("req_in_wb", {31'd0, imem_req}, 32'd0);
    endtask

    initial begin
        rst_n           = 1'b0;
        phase_fetch     = 1'b0;
        phase_writeback = 1'b0;
        stall_writeback = 1'b0;
        jump_en         = 1'b0;
        jump_addr       = 32'd0;
        imem_gnt        = 1'b0;
        imem_rvalid     = 1'b0;
        imem_rdata      = 32'd0;
        pc_m            = 32'h0000_0000;
        inst_m          = NOP;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check_eq("rst_pc", pc, 32'h0000_0000);
        check_eq("rst_inst", inst, NOP);
        check_eq("rst_req", {31'd0, imem_req}, 32'd0);
        check_eq("rst_err", {31'd0, fetch_err}, 32'd0);
        check_eq("rst_stall", {31'd0, stall_fetch}, 32'd0);
        rst_n = 1'b1;

        // No request until phase_fetch is seen high
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            imem_gnt    = 1'($urandom);
            imem_rvalid = 1'($urandom);
            check_eq("no_req_idle", {31'd0, imem_req}, 32'd0);
        end
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;

        // Minimum-latency fetch, then delayed grant/data
        do_fetch(0, 0, 32'h00A0_0093, 1'b0);
        do_fetch(2, 3, $urandom, 1'b0);

        // Wrap at the top of the address space, with one stalled cycle first
        do_wb(0, 1'b1, 32'hFFFF_FFFF);
        do_wb(1, 1'b0, 32'd0);
        check_eq("pc_wrap", pc, 32'h0000_0000);

        // Misaligned jump target, then a fetch from it
        do_wb(0, 1'b1, 32'h0000_1237);
        check_eq("pc_jump", pc, 32'h0000_1234);
        do_fetch(0, 1, $urandom, 1'b0);

        // phase_fetch dropped mid-transaction still completes
        do_fetch(1, 2, $urandom, 1'b1);

        // Randomized fetch/writeback sequences
        for (int it = 0; it < 40; it++) begin
            do_fetch(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom,
                     ($urandom_range(0, 7) == 0));
            do_wb(int'($urandom_range(0, 2)), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom);
        end

        // Reset while waiting for data abandons the transaction
        @(negedge clk);
        phase_fetch = 1'b1;
        imem_gnt    = 1'b0;
        @(negedge clk);
        check_eq("rstw_req", {31'd0, imem_req}, 32'd1);
        imem_gnt = 1'b1;
        @(negedge clk);
        phase_fetch = 1'b0;
        imem_gnt    = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("rstw_async_req", {31'd0, imem_req}, 32'd0);
        check_eq("rstw_async_pc", pc, 32'h0000_0000);
        check_eq("rstw_async_inst", inst, NOP);
        pc_m   = 32'h0000_0000;
        inst_m = NOP;
        @(negedge clk);
        rst_n       = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("rstw_inst", inst, NOP);
            check_eq("rstw_req", {31'd0, imem_req}, 32'd0);
            check_eq("rstw_pc", pc, 32'h0000_0000);
        end
        imem_rvalid = 1'b0;

        // Normal operation resumes after reset
        do_fetch(0, 0, $urandom, 1'b0);

`ifdef FETCH_TIMEOUT_EN
        begin
            int  req_c = 0;
            bit  hit   = 1'b0;
            @(negedge clk);
            phase_fetch = 1'b1;
            imem_gnt    = 1'b0;
            for (int cyc = 0; cyc < 40; cyc++) begin
                @(negedge clk);
                imem_rvalid = 1'($urandom);
                if (imem_req) req_c++;
                #1;
                if (imem_req && !stall_fetch) begin
                    hit = 1'b1;
                    check_eq("tmo_err_before", {31'd0, fetch_err}, 32'd0);
                    break;
                end
            end
            check_eq("tmo_hit", {31'd0, hit}, 32'd1);
            check_eq("tmo_req_cycles", 32'(req_c), 32'd16);
            @(negedge clk);
            phase_fetch = 1'b0;
            imem_rvalid = 1'b0;
            check_eq("tmo_err", {31'd0, fetch_err}, 32'd1);
            check_eq("tmo_inst", inst, NOP);
            check_eq("tmo_req", {31'd0, imem_req}, 32'd0);
            @(negedge clk);
            check_eq("tmo_err_sticky", {31'd0, fetch_err}, 32'd1);
        end
`else
        check_eq("err_tied_low", {31'd0, fetch_err}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
